note_sequencer: RTL

Parametrised single-channel note player that replaces a bank of fixed per-note dividers with one programmable half-period counter. Host logic (e.g. the Bluetooth command decoder) pushes (note, duration) entries into an internal FIFO over a valid/ready handshake. The block plays each entry as a square wave for an exact number of milliseconds, then inserts a fixed silent articulation gap. Its output drives the buzzer/speaker pin directly.

---
 rtl/note_sequencer_if.sv | 29 ++
 rtl/note_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer_if                                                      |
// | Host-side entry handshake (note code + duration) for note_sequencer.   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface note_sequencer_if #(
    parameter int DUR_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_note;
    logic [DUR_W-1:0] in_dur;

    modport master (
        output in_valid,
        output in_note,
        output in_dur,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_note,
        input  in_dur,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer                                                         |
// | FIFO-fed square-wave note player with ms timing and articulation gap.  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module note_sequencer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DUR_W  = 16,
    parameter int DEPTH  = 8,
    parameter int GAP_MS = 10
) (
    input  wire                      clk,
    input  wire                      rst,
    note_sequencer_if.slave          in_if,
    input  wire                      mute,
    output logic                     out,
    output logic                     playing,
    output logic [4:0]               note_cur,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int c_MS = CLK_HZ / 1000;
    localparam int c_PW = (c_MS > 1) ? $clog2(c_MS) : 1;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH) + 1;

    localparam logic [63:0] c_HM_C = (64'(CLK_HZ) * 64'd50) / 64'd26163;
    localparam logic [63:0] c_HM_D = (64'(CLK_HZ) * 64'd50) / 64'd29366;
    localparam logic [63:0] c_HM_E = (64'(CLK_HZ) * 64'd50) / 64'd32963;
    localparam logic [63:0] c_HM_F = (64'(CLK_HZ) * 64'd50) / 64'd34923;
    localparam logic [63:0] c_HM_G = (64'(CLK_HZ) * 64'd50) / 64'd39200;
    localparam logic [63:0] c_HM_A = (64'(CLK_HZ) * 64'd50) / 64'd44000;
    localparam logic [63:0] c_HM_B = (64'(CLK_HZ) * 64'd50) / 64'd49388;
    // Widest half-period is low C = 2*H_mid(C)
    localparam int c_HW = $clog2(c_HM_C * 64'd2 + 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_TONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    function automatic logic [c_HW-1:0] f_half(input logic [4:0] note);
        logic [63:0] mid;
        logic [63:0] h;
        logic [2:0]  idx;
        if (note >= 5'd15)     idx = 3'(note - 5'd15);
        else if (note >= 5'd8) idx = 3'(note - 5'd8);
        else                   idx = 3'(note - 5'd1);
        case (idx)
            3'd0:    mid = c_HM_C;
            3'd1:    mid = c_HM_D;
            3'd2:    mid = c_HM_E;
            3'd3:    mid = c_HM_F;
            3'd4:    mid = c_HM_G;
            3'd5:    mid = c_HM_A;
            3'd6:    mid = c_HM_B;
            default: mid = c_HM_C;
        endcase
        if (note >= 5'd1 && note <= 5'd7)        h = mid << 1;
        else if (note >= 5'd15 && note <= 5'd21) h = mid >> 1;
        else                                     h = mid;
        return c_HW'(h);
    endfunction

    logic [4:0]       r_mem_note [DEPTH];
    logic [DUR_W-1:0] r_mem_dur  [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_LW-1:0]  r_count;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_note;
    logic [4:0]       w_note_nxt;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] w_dur_nxt;
    logic [DUR_W-1:0] r_rem;
    logic [DUR_W-1:0] w_rem_nxt;
    logic [c_HW-1:0]  r_half;
    logic [c_HW-1:0]  w_half_nxt;
    logic [c_HW-1:0]  r_hcnt;
    logic [c_HW-1:0]  w_hcnt_nxt;
    logic [c_PW-1:0]  r_pre;
    logic [c_PW-1:0]  w_pre_nxt;
    logic             r_tone;
    logic             w_tone_nxt;
    logic             r_out;
    logic             w_pitched;
    logic             w_ms_wrap;

    assign w_ready         = (r_count < c_LW'(DEPTH));
    assign in_if.in_ready  = w_ready;
    assign w_push          = in_if.in_valid && w_ready;
    assign w_pop           = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LW'(1);
                2'b01:   r_count <= r_count - c_LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_note[r_wptr] <= in_if.in_note;
            r_mem_dur[r_wptr]  <= in_if.in_dur;
        end
    end

    assign w_pitched = (r_note != 5'd0) && (r_note <= 5'd21);
    assign w_ms_wrap = (r_pre == c_PW'(c_MS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_dur_nxt   = r_dur;
        w_rem_nxt   = r_rem;
        w_half_nxt  = r_half;
        w_hcnt_nxt  = r_hcnt;
        w_pre_nxt   = r_pre;
        w_tone_nxt  = r_tone;
        case (r_state)
            S_IDLE: begin
                w_tone_nxt = 1'b0;
                if (w_pop) begin
                    w_note_nxt  = r_mem_note[r_rptr];
                    w_dur_nxt   = r_mem_dur[r_rptr];
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_half_nxt  = f_half(r_note);
                w_rem_nxt   = r_dur;
                w_hcnt_nxt  = '0;
                w_pre_nxt   = '0;
                w_tone_nxt  = 1'b0;
                w_state_nxt = (r_dur == '0) ? S_IDLE : S_TONE;
            end
            S_TONE: begin
                if (r_hcnt == r_half - c_HW'(1)) begin
                    w_hcnt_nxt = '0;
                    if (w_pitched) w_tone_nxt = ~r_tone;
                end else begin
                    w_hcnt_nxt = r_hcnt + c_HW'(1);
                end
                if (w_ms_wrap) begin
                    w_pre_nxt = '0;
                    w_rem_nxt = r_rem - DUR_W'(1);
                    if (r_rem == DUR_W'(1)) begin
                        // The gap reuses rem/prescaler as its own ms countdown
                        w_tone_nxt = 1'b0;
                        if (GAP_MS == 0) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_rem_nxt   = DUR_W'(GAP_MS);
                            w_state_nxt = S_GAP;
                        end
                    end
                end else begin
                    w_pre_nxt = r_pre + c_PW'(1);
                end
            end
            S_GAP: begin
                w_tone_nxt = 1'b0;
                if (w_ms_wrap) begin
                    w_pre_nxt = '0;
                    w_rem_nxt = r_rem - DUR_W'(1);
                    if (r_rem == DUR_W'(1)) w_state_nxt = S_IDLE;
                end else begin
                    w_pre_nxt = r_pre + c_PW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_note  <= '0;
            r_dur   <= '0;
            r_rem   <= '0;
            r_half  <= '0;
            r_hcnt  <= '0;
            r_pre   <= '0;
            r_tone  <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_note  <= w_note_nxt;
            r_dur   <= w_dur_nxt;
            r_rem   <= w_rem_nxt;
            r_half  <= w_half_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_pre   <= w_pre_nxt;
            r_tone  <= w_tone_nxt;
            r_out   <= w_tone_nxt & ~mute;
        end
    end

    assign out        = r_out;
    assign playing    = (r_state != S_IDLE);
    assign note_cur   = (((r_state == S_LOAD) || (r_state == S_TONE)) && w_pitched) ? r_note : 5'd0;
    assign fifo_level = r_count;
endmodule
`default_nettype wire
